// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and FSM states.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_DEC = 3'b101,
    OP_INC = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load           capture a/b, clear acc, cnt=WIDTH
//   step           perform one shift-add iteration (ignored when not busy)
//   a, b           multiplicand / multiplier
//   busy           iterations remain (cnt != 0)
//   last           the current step is the final one
//   product        accumulator value after the current step completes
module mul_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    w_acc_nxt;

  // Partial product for this step is added when the multiplier LSB is set.
  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  assign busy    = (r_cnt != '0);
  assign last    = (r_cnt == CNT_W'(1));
  assign product = w_acc_nxt;

  // Iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (load) begin
      r_mcand  <= PW'(a);
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (step && busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags and valid/ready handshakes.
// Single-cycle ops complete at the accept edge; MUL iterates WIDTH steps.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid / in_ready      request handshake (in_ready is combinational)
//   op, a, b, cin            operation and operands, sampled at accept
//   out_valid / out_ready    result handshake
//   y, y_hi                  result (y_hi = MUL high half, else 0)
//   flag_z/c/n/v             zero, carry/borrow, negative, signed overflow
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int unsigned W1  = WIDTH + 1;
  localparam int unsigned MSB = WIDTH - 1;

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_y_hi;
  logic               r_z;
  logic               r_c;
  logic               r_n;
  logic               r_v;

  op_t                w_op;
  logic               w_accept;
  logic               w_mul_load;
  logic               w_mul_step;
  logic               w_mul_busy;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_opb;
  logic               w_cin;
  logic [W1-1:0]      w_sum;
  logic [W1-1:0]      w_dif;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;

  assign w_op       = op_t'(op);
  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_mul_load = w_accept && (w_op == OP_MUL);
  assign w_mul_step = (r_state == ST_EXEC) && w_mul_busy;

  mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_mul_load),
    .step    (w_mul_step),
    .a       (a),
    .b       (b),
    .busy    (w_mul_busy),
    .last    (w_mul_last),
    .product (w_product)
  );

  // Shared adder/subtractor: INC/DEC reuse it with a constant operand of 1.
  always_comb begin
    w_opb = ((w_op == OP_INC) || (w_op == OP_DEC)) ? WIDTH'(1) : b;
    w_cin = ((w_op == OP_ADD) || (w_op == OP_SUB)) ? cin : 1'b0;
    w_sum = {1'b0, a} + {1'b0, w_opb} + W1'(w_cin);
    w_dif = {1'b0, a} - {1'b0, w_opb} - W1'(w_cin);
  end

  // Single-cycle result, carry/borrow and overflow.
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_INC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == w_opb[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        w_res = w_dif[WIDTH-1:0];
        w_c   = w_dif[WIDTH];
        w_v   = (a[MSB] != w_opb[MSB]) && (w_dif[MSB] != a[MSB]);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      default: w_res = '0;
    endcase
  end

  // Control FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_y_hi      <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_state     <= ST_EXEC;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_y         <= w_res;
              r_y_hi      <= '0;
              r_z         <= (w_res == '0);
              r_c         <= w_c;
              r_n         <= w_res[MSB];
              r_v         <= w_v;
            end
          end else if (r_state == ST_DONE && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (w_mul_last) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_y         <= w_product[WIDTH-1:0];
            r_y_hi      <= w_product[2*WIDTH-1:WIDTH];
            r_z         <= (w_product == '0);
            r_c         <= (w_product[2*WIDTH-1:WIDTH] != '0);
            r_n         <= w_product[MSB];
            r_v         <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign y_hi      = r_y_hi;
  assign flag_z    = r_z;
  assign flag_c    = r_c;
  assign flag_n    = r_n;
  assign flag_v    = r_v;

endmodule

// File: tb/tb_alu_mc.sv
// Directed and randomised checks of alu_mc at WIDTH=8 and WIDTH=16.
module tb_alu_mc;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] yh;
    logic        z;
    logic        c;
    logic        n;
    logic        v;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        out_ready;
  logic        cin;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        iv8, iv16;

  logic        ir8, ov8, z8, c8, n8, v8;
  logic [7:0]  y8, yh8;
  logic        ir16, ov16, z16, c16, n16, v16;
  logic [15:0] y16, yh16;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov8), .out_ready(out_ready),
    .y(y8), .y_hi(yh8), .flag_z(z8), .flag_c(c8), .flag_n(n8), .flag_v(v8)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op),
    .a(a), .b(b), .cin(cin), .out_valid(ov16), .out_ready(out_ready),
    .y(y16), .y_hi(yh16), .flag_z(z16), .flag_c(c16), .flag_n(n16), .flag_v(v16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci);
    op  = o;
    a   = {8'h00, ai};
    b   = {8'h00, bi};
    cin = ci;
    iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
  endtask

  task automatic drain8();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Independent reference: integer arithmetic with explicit range checks.
  function automatic exp_t model(input int w, input logic [2:0] o, input logic [15:0] ai,
                                 input logic [15:0] bi, input logic ci);
    exp_t   e;
    longint m  = (longint'(1) << w) - 1;
    longint h  = longint'(1) << (w - 1);
    longint ua = longint'(ai) & m;
    longint ub = longint'(bi) & m;
    longint sa = (ua >= h) ? ua - (m + 1) : ua;
    longint sb = (ub >= h) ? ub - (m + 1) : ub;
    longint cc = longint'(ci);
    longint r  = 0;
    longint sr = 0;
    logic   arith = 1'b0;
    e = '0;
    case (o)
      3'd0: begin r = ua + ub + cc; sr = sa + sb + cc; arith = 1'b1; e.c = (r > m); end
      3'd1: begin r = ua - ub - cc; sr = sa - sb - cc; arith = 1'b1; e.c = (r < 0); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua - 1; sr = sa - 1; arith = 1'b1; e.c = (r < 0); end
      3'd6: begin r = ua + 1; sr = sa + 1; arith = 1'b1; e.c = (r > m); end
      default: begin
        r    = ua * ub;
        e.yh = 16'((r >> w) & m);
        e.c  = (e.yh != 16'h0);
      end
    endcase
    e.y = 16'(r & m);
    e.z = (o == 3'd7) ? (r == 0) : (e.y == 16'h0);
    e.n = 1'(((r & m) >> (w - 1)) & 1);
    e.v = arith && ((sr > h - 1) || (sr < -h));
    return e;
  endfunction

  task automatic sample(input int w, output logic ov, output logic ir, output exp_t s);
    if (w == 8) begin
      ov = ov8; ir = ir8;
      s  = '{y: {8'h00, y8}, yh: {8'h00, yh8}, z: z8, c: c8, n: n8, v: v8};
    end else begin
      ov = ov16; ir = ir16;
      s  = '{y: y16, yh: yh16, z: z16, c: c16, n: n16, v: v16};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 16'h0; b = 16'h0; cin = 1'b0;
    #12;
    tests_run++;
    if ({ir8, ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 1'b0, 20'h0}) begin
      tests_failed++;
      $display("FAIL reset8 got=%h want=%h", {ir8, ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 1'b0, 20'h0});
    end
    tests_run++;
    if ({ir16, ov16, y16, yh16, z16, c16, n16, v16} !== {1'b1, 1'b0, 36'h0}) begin
      tests_failed++;
      $display("FAIL reset16 got=%h", {ir16, ov16, y16, yh16, z16, c16, n16, v16});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    tests_run++;
    if (ir8 !== 1'b1) begin
      tests_failed++; $display("FAIL add_ready got=%b want=1", ir8);
    end
    issue8(3'd0, 8'hFF, 8'h01, 1'b0);
    tests_run++;
    if ({ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 8'h00, 8'h00, 4'b1100}) begin
      tests_failed++;
      $display("FAIL add_ff_01 got=%h want=%h", {ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 8'h00, 8'h00, 4'b1100});
    end
    drain8();
    tests_run++;
    if ({ov8, ir8, y8, z8, c8} !== {1'b0, 1'b1, 8'h00, 2'b11}) begin
      tests_failed++;
      $display("FAIL add_drain got=%h want=%h", {ov8, ir8, y8, z8, c8},
               {1'b0, 1'b1, 8'h00, 2'b11});
    end
  endtask

  task automatic test_sub_dec();
    issue8(3'd1, 8'h80, 8'h01, 1'b0);
    tests_run++;
    if ({ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 8'h7F, 8'h00, 4'b0001}) begin
      tests_failed++;
      $display("FAIL sub_80_01 got=%h want=%h", {ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 8'h7F, 8'h00, 4'b0001});
    end
    drain8();
    issue8(3'd5, 8'h00, 8'h5A, 1'b1);
    tests_run++;
    if ({ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 8'hFF, 8'h00, 4'b0110}) begin
      tests_failed++;
      $display("FAIL dec_00 got=%h want=%h", {ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 8'hFF, 8'h00, 4'b0110});
    end
    drain8();
  endtask

  task automatic test_mul();
    logic busy_ok;
    issue8(3'd7, 8'hC8, 8'h03, 1'b0);
    // Changing inputs mid-operation must not disturb the captured product.
    iv8 = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001;
    busy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ({ir8, ov8} !== 2'b00) busy_ok = 1'b0;
      tick();
    end
    iv8 = 1'b0;
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++; $display("FAIL mul_exec_busy got=0 want=1");
    end
    tests_run++;
    if ({ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 8'h58, 8'h02, 4'b0100}) begin
      tests_failed++;
      $display("FAIL mul_200_3 got=%h want=%h", {ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 8'h58, 8'h02, 4'b0100});
    end
    drain8();
  endtask

  task automatic test_back_to_back();
    logic hold_ok;
    issue8(3'd0, 8'h11, 8'h22, 1'b0);
    hold_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if ({ov8, ir8, y8, yh8, z8, c8, n8, v8} !== {2'b10, 8'h33, 8'h00, 4'b0000})
        hold_ok = 1'b0;
      tick();
    end
    tests_run++;
    if (hold_ok !== 1'b1) begin
      tests_failed++; $display("FAIL backpressure_hold got=0 want=1");
    end
    out_ready = 1'b1; iv8 = 1'b1; op = 3'd2; a = 16'h00F0; b = 16'h003C; cin = 1'b0;
    #1;
    tests_run++;
    if (ir8 !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_ready got=%b want=1", ir8);
    end
    tick();
    iv8 = 1'b0;
    tests_run++;
    if ({ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 8'h30, 8'h00, 4'b0000}) begin
      tests_failed++;
      $display("FAIL b2b_and got=%h want=%h", {ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 8'h30, 8'h00, 4'b0000});
    end
    tick();
    out_ready = 1'b0;
    tests_run++;
    if ({ov8, y8} !== {1'b0, 8'h30}) begin
      tests_failed++; $display("FAIL b2b_idle got=%h want=%h", {ov8, y8}, {1'b0, 8'h30});
    end
  endtask

  task automatic test_reset_mid_mul();
    logic quiet;
    issue8(3'd7, 8'hC8, 8'h03, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #2;
    tests_run++;
    if ({ir8, ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 1'b0, 20'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid_mul got=%h want=%h", {ir8, ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 1'b0, 20'h0});
    end
    #2;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov8 !== 1'b0) quiet = 1'b0;
    end
    tests_run++;
    if (quiet !== 1'b1) begin
      tests_failed++; $display("FAIL reset_discard got=0 want=1");
    end
    issue8(3'd6, 8'h7F, 8'h00, 1'b0);
    tests_run++;
    if ({ov8, y8, yh8, z8, c8, n8, v8} !== {1'b1, 8'h80, 8'h00, 4'b0011}) begin
      tests_failed++;
      $display("FAIL inc_7f got=%h want=%h", {ov8, y8, yh8, z8, c8, n8, v8},
               {1'b1, 8'h80, 8'h00, 4'b0011});
    end
    drain8();
  endtask

  task automatic test_random(input int w);
    exp_t q[$];
    exp_t s;
    exp_t e;
    logic ov, ir, iv;
    int   budget;
    for (int i = 0; i < 300; i++) begin
      sample(w, ov, ir, s);
      out_ready = ($urandom_range(0, 3) != 0);
      iv        = 1'($urandom_range(0, 1));
      op        = 3'($urandom_range(0, 7));
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom_range(0, 1));
      if (w == 8) iv8 = iv; else iv16 = iv;
      #1;
      sample(w, ov, ir, e);
      if (ov && out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++; $display("FAIL rand%0d_extra got=%h want=none", w, s);
        end else begin
          e = q.pop_front();
          if (s !== e) begin
            tests_failed++; $display("FAIL rand%0d_result got=%h want=%h", w, s, e);
          end
        end
      end
      if (iv && ir) q.push_back(model(w, op, a, b, cin));
      tick();
    end
    iv8 = 1'b0; iv16 = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (q.size() != 0 && budget < 100) begin
      sample(w, ov, ir, s);
      if (ov) begin
        tests_run++;
        e = q.pop_front();
        if (s !== e) begin
          tests_failed++; $display("FAIL rand%0d_drain got=%h want=%h", w, s, e);
        end
      end
      tick();
      budget++;
    end
    tests_run++;
    if (q.size() != 0) begin
      tests_failed++; $display("FAIL rand%0d_timeout pending=%0d want=0", w, q.size());
    end
    tick();
    sample(w, ov, ir, s);
    tests_run++;
    if (ov !== 1'b0) begin
      tests_failed++; $display("FAIL rand%0d_dup got=%b want=0", w, ov);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_dec();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random(8);
    test_random(16);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU, the successor to the combinational adder, decrement, and AND blocks and the 4-input mux. It adds a full 8-operation set, registered results with status flags, a valid/ready handshake on both sides, and an iterative shift-add unsigned multiplier. It sits between the register file read stage and writeback in the processor datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), multiply step counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
op  in  3  operation code (see Behaviour)
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry/borrow in (ADD/SUB only)
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes result this cycle
y  out  WIDTH  result (low half for MUL)
y_hi  out  WIDTH  high half of MUL product; 0 for other ops
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
flag_n  out  1  negative flag, y[WIDTH-1]
flag_v  out  1  signed overflow flag

Behaviour:
- Op codes:
  - 000 ADD a+b+cin; 001 SUB a-b-cin; 010 AND; 011 OR; 100 XOR.
  - 101 DEC a-1; 110 INC a+1; 111 MUL, unsigned a*b giving {y_hi,y}.
- States: IDLE, EXEC (MUL only), DONE.
- Handshake:
  - Accept occurs on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), combinational from state and out_ready only.
  - out_valid = (state==DONE), registered.
  - op, a, b and cin are captured at accept; later input changes are ignored.
- Single-cycle ops:
  - Accepted at edge k; the result and flags are registered at edge k; out_valid is high in the cycle after edge k.
  - Next state is DONE.
- MUL:
  - At accept, load the multiplicand register, the multiplier register, acc=0 and cnt=WIDTH; next state is EXEC.
  - Each EXEC edge: if the multiplier LSB is set, add the multiplicand to acc; shift; decrement cnt.
  - On the edge where cnt reaches 0, write {y_hi,y} and the flags, and go to DONE.
  - out_valid rises after edge k+WIDTH. in_ready=0 throughout EXEC.
- DONE:
  - y, y_hi and all flags hold stable while out_ready=0.
  - out_ready=1 with no new accept: go to IDLE, out_valid falls, y and flags hold their last values.
  - out_ready=1 with a simultaneous accept: process the new op exactly as from IDLE (back-to-back, one result per cycle for single-cycle ops).
- Flags:
  - flag_z: result==0; for MUL, {y_hi,y}==0.
  - flag_c: carry-out for ADD/INC; borrow for SUB/DEC (DEC: a==0); y_hi!=0 for MUL; 0 for AND/OR/XOR.
  - flag_v: two's-complement overflow for ADD/SUB/INC/DEC; 0 for all other ops.
  - flag_n: result MSB for all ops.
- Widths: internal adder is WIDTH+1 bits; product is 2*WIDTH; all arithmetic wraps modulo 2^WIDTH in y.
- Reset (rst_n low, any time including mid-EXEC):
  - state=IDLE; y, y_hi, all flags, out_valid, acc and cnt = 0.
  - in_ready=1 as soon as state is IDLE.
  - Any in-flight MUL is discarded; no result is ever emitted for it.

Decomposition:
- Package alu_mc_pkg: op_t enum (the 8 codes above) and state_t enum (IDLE, EXEC, DONE).
- Sub-module mul_shift_add: holds the multiplicand, multiplier, acc and cnt registers. Its interface is load/step in and busy/last/product out.
- The top level holds the FSM, the combinational single-cycle datapath, the flag logic and the output registers.

Test Plan:
- ADD a=FF b=01 cin=0 -> y=00, z=1, c=1, v=0, n=0; out_valid high the cycle after accept.
- SUB a=80 b=01 cin=0 -> y=7F, v=1, c=0, n=0; DEC a=00 -> y=FF, c=1, n=1, v=0.
- MUL a=200 b=3 -> y_hi=02, y=58, c=1, z=0; in_ready=0 during 8 EXEC cycles; out_valid rises 8 edges after accept.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD result -> y/flags unchanged, in_ready=0. Then out_ready=1 with in_valid=1, AND a=F0 b=3C -> next cycle y=30, out_valid stays high (no bubble).
- Reset pulse during the 4th EXEC cycle of MUL -> out_valid=0, y=0, y_hi=0, flags=0, in_ready=1. A following INC a=7F -> y=80, v=1, n=1.
- Random ops at WIDTH=8 and WIDTH=16 with random out_ready -> every result matches the reference model, in order, with no drops or duplicates.
